shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle shift unit for the datapath. It accepts one operand, a shift amount and an operation, then iterates a small shift step over several cycles until the full amount is applied. It sits beside the ALU and serves the shift instructions (SLL/SRL/SRA/ROTR) that the fixed-by-2 address shifter cannot cover. It connects through valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result; held stable while out_valid=1.
- flush  in  1  synchronous abort of any in-flight operation.
- busy  out  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch acc←in_data, cnt←in_shamt and op←in_op.
  - Next state is SHIFT if in_shamt≠0, otherwise DONE.
- SHIFT, one step per cycle:
  - If cnt≥4: shift acc by 4 and set cnt−=4.
  - Otherwise: shift acc by 1 and set cnt−=1.
  - When the updated cnt is 0, go to DONE.
- Step semantics:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with acc[WIDTH-1], sampled each step.
  - ROTR moves the low bits to the top.
- DONE:
  - out_valid=1 and out_data=acc.
  - On out_ready, go to IDLE.
  - in_ready stays 0 until that return, so there is no overlap between requests.
- flush=1 in any state:
  - Next state is IDLE; cnt is cleared.
  - A result in DONE is dropped even if out_ready=1 in the same cycle.
  - flush takes priority over every other transition.
- When flush and in_valid are both high in IDLE, the request is not accepted (in_ready is still 1 combinationally, but flush wins). The requester must treat this case as not accepted.
- Width rules:
  - cnt is SHW bits.
  - The result equals the single-cycle reference shift of in_data by in_shamt, with amount taken mod WIDTH.

## Timing
- Reset values:
  - state=IDLE, acc=0, cnt=0, op=00.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
- Call the accepting edge E0 (in_valid & in_ready & ~flush).
- out_valid rises after edge E0+k, where k=floor(s/4)+(s mod 4).
  - s=0 gives k=0: out_valid is high in the cycle after E0.
  - s=31 gives k=10: worst case.
- Results leave on the edge where out_valid & out_ready.
- in_ready rises in the cycle after the result is accepted. Back-to-back throughput is one request per k+2 cycles.
- out_data and out_valid are registered, with no combinational path from in_* to out_*.
- in_ready and busy decode directly from the state register.
- An rst_n assertion mid-operation immediately forces the reset values listed above; no partial result is ever emitted.

## Structure
- Package shift_seq_pkg holds:
  - the op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROTR);
  - the state enum (S_IDLE, S_SHIFT, S_DONE);
  - the step constant STEP_BIG=4.
- One sub-module, shift_step: purely combinational.
  - Inputs: acc, op, a big/small step select.
  - Output: the next acc.
- The top level holds only the FSM, cnt, acc and the handshake logic.

## Test plan
- in_data=32'h00000001, SLL, shamt=2 → out_data=32'h00000004, out_valid after E0+2.
- in_data=32'hF0F0F0F0, SRA, shamt=4 → 32'hFF0F0F0F, out_valid after E0+1; also SRL → 32'h0F0F0F0F.
- in_data=32'hAAAAAAAA, ROTR, shamt=31 → 32'h55555555, out_valid after E0+10; busy high throughout.
- shamt=0, SLL, in_data=32'h0000000F:
  - expect 32'h0000000F after E0.
  - Hold out_ready=0 for 5 cycles: out_valid and out_data stay stable and in_ready stays 0.
- Flush case:
  - in_data=32'h00000001, SLL, shamt=20; assert flush 3 cycles after E0.
  - Expect IDLE next cycle, no out_valid, busy=0.
  - A new request (32'h2, SLL, 1) then returns 32'h4.
- Reset case:
  - Assert rst_n=0 asynchronously mid-SHIFT and also in DONE.
  - All outputs reach their reset values immediately.
  - After release, the first request completes correctly.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: operation codes,
// FSM states and the large step size.
package shift_seq_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam int STEP_BIG = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: moves acc by STEP_BIG or by one position
// according to the selected operation.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    input  logic             big,
    output logic [WIDTH-1:0] next_acc
);

    logic [SHW-1:0]     amt_s;
    logic [2*WIDTH-1:0] rot_s;

    assign amt_s = big ? SHW'(STEP_BIG) : {{(SHW-1){1'b0}}, 1'b1};
    // Rotating a doubled word right leaves the rotated value in the low half.
    assign rot_s = {acc, acc} >> amt_s;

    // Select the shifted value for the current operation.
    always_comb begin
        next_acc = acc;
        case (op)
            OP_SLL:  next_acc = acc << amt_s;
            OP_SRL:  next_acc = acc >> amt_s;
            OP_SRA:  next_acc = $unsigned($signed(acc) >>> amt_s);
            OP_ROTR: next_acc = rot_s[WIDTH-1:0];
            default: next_acc = acc;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: accepts one request, applies the shift in steps of
// four or one bit per cycle, then presents the result until it is taken.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic             busy
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [SHW-1:0]   cnt_r;
    logic [SHW-1:0]   cnt_nxt_s;
    logic [1:0]       op_r;
    logic [1:0]       op_nxt_s;
    logic             big_s;
    logic [SHW-1:0]   step_amt_s;
    logic [WIDTH-1:0] step_acc_s;

    assign big_s      = (cnt_r >= SHW'(STEP_BIG));
    assign step_amt_s = big_s ? SHW'(STEP_BIG) : {{(SHW-1){1'b0}}, 1'b1};

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_r),
        .op       (op_r),
        .big      (big_s),
        .next_acc (step_acc_s)
    );

    // Next-state and datapath update; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        if (flush) begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = {SHW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_nxt_s   = in_data;
                        cnt_nxt_s   = in_shamt;
                        op_nxt_s    = in_op;
                        state_nxt_s = (in_shamt != {SHW{1'b0}}) ? S_SHIFT : S_DONE;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_SHIFT: begin
                    acc_nxt_s = step_acc_s;
                    cnt_nxt_s = cnt_r - step_amt_s;
                    if (cnt_nxt_s == {SHW{1'b0}}) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_SHIFT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_DONE;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = {SHW{1'b0}};
                end
            endcase
        end
    end

    // State, accumulator, count and operation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {SHW{1'b0}};
            op_r    <= OP_SLL;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign busy      = (state_r == S_SHIFT) || (state_r == S_DONE);
    assign out_data  = acc_r;

endmodule
